mult_rr_arbiter: RTL and testbench
==================================

Name: mult_rr_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one seq_mult_256bit (256x256 multiply, then reduce mod 2^255-19) between N_REQ requesters, such as the point-add and point-double units.
- Grants one requester at a time and latches its operands.
- Drives the multiplier's start/done handshake and routes the reduced 256-bit result back to the granted requester with a one-cycle done pulse.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- W, 256, operand/result width
- DRAIN_CYCLES, 1024, post-reset hold-off; must exceed worst-case multiplier latency (multiply plus mod)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- req  in  N_REQ  per-requester request level
- req_a  in  N_REQ*W  operand A, requester i at bits [i*W +: W]
- req_b  in  N_REQ*W  operand B, same packing
- ack  out  N_REQ  one-cycle pulse: operands of requester i captured
- done  out  N_REQ  one-cycle pulse: result valid for requester i
- result  out  W  last reduced product, held until next done
- busy  out  1  high in any state other than IDLE
- mult_start  out  1  to multiplier start
- mult_a  out  W  to multiplier a (registered)
- mult_b  out  W  to multiplier b (registered)
- mult_product  in  2W  from multiplier product; reduced result in [W-1:0]
- mult_done  in  1  from multiplier done2 (one-cycle pulse)

Behaviour:
- Reset values: ack=0, done=0, result=0, mult_start=0, mult_a=0, mult_b=0, busy=1, rr pointer=0, state=DRAIN, drain counter=DRAIN_CYCLES-1.
- States: DRAIN, IDLE, ISSUE, WAIT, RESP.
- DRAIN:
  - Decrement counter each cycle; go to IDLE when counter = 0.
  - Ignore and discard mult_done. The multiplier has no reset, so an operation in flight at rst is allowed to finish unobserved.
- IDLE:
  - If any req bit is set, pick the first set bit at or above the pointer, wrapping modulo N_REQ → g.
  - Latch mult_a=req_a[g], mult_b=req_b[g] and store g.
  - Pulse ack[g] in the same clock edge (visible the cycle after selection); go to ISSUE.
  - If no req bit is set, stay in IDLE.
- ISSUE: mult_start=1 for exactly this one cycle; go to WAIT.
- WAIT:
  - mult_start=0. Hold mult_a/mult_b stable.
  - On mult_done: result ← mult_product[W-1:0]; go to RESP.
- RESP:
  - done[g]=1 for one cycle; pointer ← (g+1) mod N_REQ; go to IDLE.
  - The earliest next mult_start is 2 cycles after RESP. This guarantees the multiplier is back in its INIT state.
- Requester rules:
  - Hold req and operands stable until ack.
  - After ack, operands may change; req may stay high for a new operation.
  - A req that is still high in the IDLE cycle following RESP is treated as a new request.
  - Dropping req before ack withdraws the request, with no side effect.
- Fairness: a granted requester has lowest priority next round. With all N_REQ requesting continuously, grants rotate 0,1,2,3,0...
- Only one ack and one done are ever high at a time. done and ack are never high in the same cycle.
- mult_done outside WAIT/DRAIN is a protocol error: ignore it, no state change.
- rst mid-operation (any state): all outputs return to reset values next cycle and state goes to DRAIN. No done is issued for the aborted operation.
- Total per-operation latency, ack to done: 2 + multiplier latency + 1 cycles.

Test Plan:
- Single op: rst, wait drain, req[0]=1 with a=3, b=5 → ack[0] pulse; mult_start one cycle later; done[0] with result=15; busy low afterward.
- Modular wrap: a=b=2^255-20 (p-1) on requester 2 → done[2], result=1. Then a=2^255-18, b=2 → result=2 (since a≡1 mod p).
- Round robin: req=4'b1111 held, each requester's operands distinct → grant order 0,1,2,3,0. Each done carries that requester's product. No overlapping ack/done.
- Priority rotation: after grant 2, req=4'b0101 → next grant 0 (wrap, skipping 3), then 2.
- Reset mid-op: assert rst during WAIT for one cycle → no done; busy=1 for DRAIN_CYCLES cycles; stray multiplier done2 ignored. A subsequent req[1] with a=7, b=9 → result=63.
- Back-to-back: req[3] held high with new operands after ack → second ack no sooner than 2 cycles after first done. Multiplier receives both starts cleanly and both results are correct.

Source files
------------

// File: rtl/mult_rr_arbiter.sv
// Round-robin arbiter that shares a single modular multiplier between N_REQ requesters.
// It latches the granted operands, runs the start/done handshake and returns the reduced result.
module mult_rr_arbiter #(
    parameter int N_REQ        = 4,
    parameter int W            = 256,
    parameter int DRAIN_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] req_a,
    input  logic [N_REQ*W-1:0] req_b,
    output logic [N_REQ-1:0]   ack,
    output logic [N_REQ-1:0]   done,
    output logic [W-1:0]       result,
    output logic               busy,
    output logic               mult_start,
    output logic [W-1:0]       mult_a,
    output logic [W-1:0]       mult_b,
    input  logic [2*W-1:0]     mult_product,
    input  logic               mult_done
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);
    localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);
    localparam logic [IDX_W:0]   N_REQ_W  = (IDX_W + 1)'(N_REQ);

    typedef enum logic [2:0] {
        S_DRAIN,
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   grant;
    logic [IDX_W-1:0]   sel_idx;
    logic               sel_found;
    logic [IDX_W:0]     cand;
    logic [IDX_W-1:0]   cand_idx;
    logic [CNT_W-1:0]   drain_cnt;
    logic               unused_product_hi;

    // Only the reduced low half of the multiplier product is meaningful.
    assign unused_product_hi = ^mult_product[2*W-1:W];

    assign busy = (state != S_IDLE);

    // First requesting index at or above the pointer, wrapping modulo N_REQ.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        cand_idx  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, ptr} + (IDX_W + 1)'(k);
            if (cand >= N_REQ_W) begin
                cand = cand - N_REQ_W;
            end
            cand_idx = cand[IDX_W-1:0];
            if (!sel_found && req[cand_idx]) begin
                sel_found = 1'b1;
                sel_idx   = cand_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_DRAIN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_DRAIN: if (drain_cnt == '0) state_next = S_IDLE;
            S_IDLE:  if (sel_found) state_next = S_ISSUE;
            S_ISSUE: state_next = S_WAIT;
            S_WAIT:  if (mult_done) state_next = S_RESP;
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_DRAIN;
        endcase
    end

    // DRAIN lets a multiply in flight across reset finish unobserved, since the multiplier has no reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack        <= '0;
            done       <= '0;
            result     <= '0;
            mult_start <= 1'b0;
            mult_a     <= '0;
            mult_b     <= '0;
            ptr        <= '0;
            grant      <= '0;
            drain_cnt  <= CNT_W'(DRAIN_CYCLES - 1);
        end else begin
            ack        <= '0;
            done       <= '0;
            mult_start <= 1'b0;
            case (state)
                S_DRAIN: begin
                    if (drain_cnt != '0) begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                S_IDLE: begin
                    if (sel_found) begin
                        grant  <= sel_idx;
                        mult_a <= req_a[sel_idx*W +: W];
                        mult_b <= req_b[sel_idx*W +: W];
                        ack    <= ONE_HOT0 << sel_idx;
                    end
                end
                S_ISSUE: mult_start <= 1'b1;
                S_WAIT: begin
                    if (mult_done) begin
                        result <= mult_product[W-1:0];
                        done   <= ONE_HOT0 << grant;
                    end
                end
                S_RESP: ptr <= (grant == LAST_IDX) ? '0 : grant + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_rr_arbiter.sv
// Directed self-checking bench for mult_rr_arbiter with a latency-modelled multiplier stub
// and a scoreboard of expected grants and results.
module tb_mult_rr_arbiter;

    localparam int N_REQ = 4;
    localparam int W     = 256;
    localparam int DRAIN = 16;
    localparam int LAT   = 5;
    localparam logic [W-1:0] P = (256'd1 << 255) - 256'd19;

    typedef struct {
        int         idx;
        logic [W-1:0] val;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [N_REQ-1:0]   req = '0;
    logic [N_REQ*W-1:0] req_a = '0;
    logic [N_REQ*W-1:0] req_b = '0;
    logic [N_REQ-1:0]   ack;
    logic [N_REQ-1:0]   done;
    logic [W-1:0]       result;
    logic               busy;
    logic               mult_start;
    logic [W-1:0]       mult_a;
    logic [W-1:0]       mult_b;
    logic [2*W-1:0]     mult_product = '0;
    logic               mult_done;

    logic               model_done = 1'b0;
    logic               inject_done = 1'b0;
    logic [W-1:0]       m_a = '0;
    logic [W-1:0]       m_b = '0;
    int                 m_cnt = 0;
    int                 starts = 0;
    int                 overlap_err = 0;
    int                 cyc = 0;

    int                 tests_run = 0;
    int                 tests_failed = 0;
    int                 ack_q[$];
    exp_t               res_q[$];

    mult_rr_arbiter #(.N_REQ(N_REQ), .W(W), .DRAIN_CYCLES(DRAIN)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_a        (req_a),
        .req_b        (req_b),
        .ack          (ack),
        .done         (done),
        .result       (result),
        .busy         (busy),
        .mult_start   (mult_start),
        .mult_a       (mult_a),
        .mult_b       (mult_b),
        .mult_product (mult_product),
        .mult_done    (mult_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] modmul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] prod;
        prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        prod = prod % {{W{1'b0}}, P};
        return prod[W-1:0];
    endfunction

    // Multiplier stub: no reset, fixed latency, garbage in the upper half of the product.
    assign mult_done = model_done | inject_done;

    always @(posedge clk) begin
        model_done <= 1'b0;
        if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                model_done   <= 1'b1;
                mult_product <= {~modmul(m_a, m_b), modmul(m_a, m_b)};
            end
        end
        if (mult_start) begin
            if (m_cnt != 0) overlap_err <= overlap_err + 1;
            m_a    <= mult_a;
            m_b    <= mult_b;
            m_cnt  <= LAT;
            starts <= starts + 1;
        end
    end

    task automatic check_output(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: every ack and done must match the next expected entry.
    always @(negedge clk) begin : monitor
        exp_t e;
        int   ai;
        if (ack != '0) begin
            if (ack_q.size() == 0) begin
                check_output("ack_unexpected", ack, 0);
            end else begin
                ai = ack_q.pop_front();
                check_output("ack_index", ack, 1 << ai);
            end
        end
        if (done != '0) begin
            if (res_q.size() == 0) begin
                check_output("done_unexpected", done, 0);
            end else begin
                e = res_q.pop_front();
                check_output("done_index", done, 1 << e.idx);
                check_output("done_result", result, e.val);
            end
        end
        if ((ack != '0) || (done != '0)) begin
            check_output("ack_done_overlap", (ack != '0) && (done != '0), 0);
        end
    end

    task automatic apply_stimulus(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req[i]          = 1'b1;
    endtask

    task automatic expect_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        ack_q.push_back(i);
        res_q.push_back('{idx: i, val: modmul(a, b)});
    endtask

    task automatic wait_ack(input int i);
        int n = 0;
        while (ack[i] !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check_output($sformatf("ack%0d_seen", i), ack[i], 1);
    endtask

    task automatic wait_done(input int i);
        int n = 0;
        while (done[i] !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check_output($sformatf("done%0d_seen", i), done[i], 1);
    endtask

    task automatic check_drain(input string tag);
        int n = 0;
        while (busy === 1'b1 && n < DRAIN + 50) begin
            @(negedge clk);
            n++;
        end
        check_output(tag, n, DRAIN);
    endtask

    task automatic run_single(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] want, input string tag);
        expect_op(i, a, b);
        apply_stimulus(i, a, b);
        wait_ack(i);
        req[i] = 1'b0;
        wait_done(i);
        check_output(tag, result, want);
        @(negedge clk);
    endtask

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t_done;
        int t_ack2;

        // Reset values
        repeat (3) @(negedge clk);
        check_output("rst_busy", busy, 1);
        check_output("rst_ack", ack, 0);
        check_output("rst_done", done, 0);
        check_output("rst_result", result, 0);
        check_output("rst_mult_start", mult_start, 0);
        check_output("rst_mult_a", mult_a, 0);
        rst = 1'b0;
        check_drain("drain_len_initial");

        // Single op with start timing
        expect_op(0, 3, 5);
        apply_stimulus(0, 3, 5);
        wait_ack(0);
        req[0] = 1'b0;
        check_output("single_start_before", mult_start, 0);
        @(negedge clk);
        check_output("single_start", mult_start, 1);
        check_output("single_mult_a", mult_a, 3);
        check_output("single_mult_b", mult_b, 5);
        @(negedge clk);
        check_output("single_start_pulse", mult_start, 0);
        wait_done(0);
        check_output("single_result", result, 15);
        @(negedge clk);
        check_output("single_busy_after", busy, 0);

        // Stray mult_done while idle is ignored
        inject_done = 1'b1;
        @(negedge clk);
        inject_done = 1'b0;
        @(negedge clk);
        check_output("stray_busy", busy, 0);
        check_output("stray_result", result, 15);

        // Modular wrap on requester 2
        run_single(2, P - 1, P - 1, 1, "mod_p_minus_1_sq");
        run_single(2, P + 1, 2, 2, "mod_p_plus_1_x2");

        // Grant 3 so the pointer wraps to 0
        run_single(3, 11, 13, 143, "single_req3");

        // Round robin with all four requesting
        expect_op(0, 101, 201);
        expect_op(1, 102, 202);
        expect_op(2, 103, 203);
        expect_op(3, 104, 204);
        expect_op(0, 105, 205);
        for (int i = 0; i < N_REQ; i++) apply_stimulus(i, 101 + i, 201 + i);
        wait_ack(0);
        apply_stimulus(0, 105, 205);
        wait_ack(1);
        wait_ack(2);
        wait_ack(3);
        wait_ack(0);
        req = '0;
        wait_done(0);
        check_output("rr_last_result", result, 105 * 205);
        @(negedge clk);

        // Priority rotation: after grant 2, 0101 grants 0 then 2
        run_single(2, 6, 7, 42, "prio_pre_grant2");
        expect_op(0, 8, 9);
        expect_op(2, 10, 11);
        apply_stimulus(0, 8, 9);
        apply_stimulus(2, 10, 11);
        wait_ack(0);
        wait_ack(2);
        req = '0;
        wait_done(2);
        check_output("prio_result2", result, 110);
        @(negedge clk);

        // Reset during WAIT: no done, full drain, stray done ignored
        ack_q.push_back(1);
        apply_stimulus(1, 21, 2);
        wait_ack(1);
        req[1] = 1'b0;
        @(negedge clk);
        check_output("midrst_start", mult_start, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_output("midrst_busy", busy, 1);
        check_output("midrst_result", result, 0);
        check_output("midrst_mult_a", mult_a, 0);
        check_output("midrst_done", done, 0);
        check_drain("drain_len_midrst");
        run_single(1, 7, 9, 63, "post_rst_result");

        // Back-to-back on requester 3
        expect_op(3, 100, 200);
        expect_op(3, P - 1, 3);
        apply_stimulus(3, 100, 200);
        wait_ack(3);
        apply_stimulus(3, P - 1, 3);
        wait_done(3);
        t_done = cyc;
        check_output("b2b_first_result", result, 20000);
        @(negedge clk);
        wait_ack(3);
        t_ack2 = cyc;
        req[3] = 1'b0;
        check_output("b2b_gap_ge2", (t_ack2 - t_done) >= 2, 1);
        wait_done(3);
        check_output("b2b_second_result", result, P - 3);
        repeat (3) @(negedge clk);

        // End-of-run accounting
        check_output("ack_queue_empty", ack_q.size(), 0);
        check_output("res_queue_empty", res_q.size(), 0);
        check_output("mult_overlap", overlap_err, 0);
        check_output("mult_start_count", starts, 16);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
